// File: rtl/nvme_pcie_rxrc.sv
// Receives RC completions for CfgRd0/MRd_64, checks the tag and length, and presents up to two payload dwords with byte parity on a valid/ack handshake.
// Define NVME_RXRC_PARCHK_EN to enable the per-byte tdata parity checker that drives user_rxrc_perror_ind.
module nvme_pcie_rxrc #(
    parameter int bits_per_parity_bit = 8,
    parameter int cnt_width           = 16
) (
    input  logic                                 user_clk,
    input  logic                                 user_reset_n,
    input  logic [127:0]                         m_axis_rc_tdata,
    input  logic [3:0]                           m_axis_rc_tkeep,
    input  logic                                 m_axis_rc_tlast,
    input  logic [74:0]                          m_axis_rc_tuser,
    input  logic                                 m_axis_rc_tvalid,
    output logic [21:0]                          m_axis_rc_tready,
    output logic                                 rxrc_ctl_valid,
    output logic [5:0]                           rxrc_ctl_tag,
    output logic [63:0]                          rxrc_ctl_data,
    output logic [64/bits_per_parity_bit-1:0]    rxrc_ctl_datap,
    output logic [2:0]                           rxrc_ctl_status,
    output logic                                 rxrc_ctl_err,
    input  logic                                 ctl_rxrc_ack,
    output logic [cnt_width-1:0]                 rxrc_discard_cnt,
    output logic                                 user_rxrc_perror_ind
);

    localparam int NPAR = 64 / bits_per_parity_bit;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA2 = 2'd1,
        S_DROP  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic [5:0]             tag_q, tag_d;
    logic [63:0]            data_q, data_d;
    logic [NPAR-1:0]        datap_q, datap_d;
    logic [2:0]             status_q, status_d;
    logic                   err_q, err_d;
    logic                   pdrop_q, pdrop_d;
    logic [cnt_width-1:0]   disc_q, disc_d;

    logic [10:0]            dw_cnt;
    logic [2:0]             cpl_status;
    logic                   poisoned;
    logic [7:0]             cpl_tag;
    logic                   discontinue;
    logic                   beat_ok;

    assign dw_cnt      = m_axis_rc_tdata[42:32];
    assign cpl_status  = m_axis_rc_tdata[45:43];
    assign poisoned    = m_axis_rc_tdata[46];
    assign cpl_tag     = m_axis_rc_tdata[71:64];
    assign discontinue = m_axis_rc_tuser[42];
    assign beat_ok     = m_axis_rc_tvalid && (state_q != S_HOLD);

    // Held low during reset so the core sees no acceptance while we are abandoning state.
    assign m_axis_rc_tready = {22{(state_q != S_HOLD) && user_reset_n}};

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;
        status_d = status_q;
        err_d    = err_q;
        pdrop_d  = pdrop_q;
        disc_d   = disc_q;
        case (state_q)
            S_IDLE: begin
                if (m_axis_rc_tvalid) begin
                    if ((cpl_tag[7:6] != 2'b00) || (dw_cnt > 11'd2)) begin
                        disc_d  = (&disc_q) ? disc_q : disc_q + 1'b1;
                        state_d = m_axis_rc_tlast ? S_IDLE : S_DROP;
                    end else begin
                        tag_d    = cpl_tag[5:0];
                        status_d = cpl_status;
                        pdrop_d  = !m_axis_rc_tlast;
                        valid_d  = 1'b1;
                        state_d  = S_HOLD;
                        if (cpl_status != 3'd0) begin
                            data_d = 64'h0;
                            err_d  = 1'b1;
                        end else if ((dw_cnt == 11'd2) && !m_axis_rc_tlast) begin
                            data_d  = {32'h0, m_axis_rc_tdata[127:96]};
                            err_d   = poisoned || discontinue;
                            pdrop_d = 1'b0;
                            valid_d = 1'b0;
                            state_d = S_DATA2;
                        end else begin
                            // A two-dword completion ending on its first beat is short.
                            data_d = {32'h0, m_axis_rc_tdata[127:96]};
                            err_d  = poisoned || discontinue || (dw_cnt == 11'd2);
                        end
                    end
                end
            end
            S_DATA2: begin
                if (m_axis_rc_tvalid) begin
                    data_d[63:32] = m_axis_rc_tdata[31:0];
                    err_d         = err_q || discontinue;
                    pdrop_d       = !m_axis_rc_tlast;
                    valid_d       = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_DROP: begin
                if (m_axis_rc_tvalid && m_axis_rc_tlast) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (ctl_rxrc_ack) begin
                    valid_d = 1'b0;
                    pdrop_d = 1'b0;
                    state_d = pdrop_q ? S_DROP : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        datap_d = '0;
        for (int i = 0; i < NPAR; i++) begin
            datap_d[i] = ~^data_d[i*bits_per_parity_bit +: bits_per_parity_bit];
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            tag_q    <= '0;
            data_q   <= '0;
            datap_q  <= '0;
            status_q <= '0;
            err_q    <= 1'b0;
            pdrop_q  <= 1'b0;
            disc_q   <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            datap_q  <= datap_d;
            status_q <= status_d;
            err_q    <= err_d;
            pdrop_q  <= pdrop_d;
            disc_q   <= disc_d;
        end
    end

    assign rxrc_ctl_valid   = valid_q;
    assign rxrc_ctl_tag     = tag_q;
    assign rxrc_ctl_data    = data_q;
    assign rxrc_ctl_datap   = datap_q;
    assign rxrc_ctl_status  = status_q;
    assign rxrc_ctl_err     = err_q;
    assign rxrc_discard_cnt = disc_q;

`ifdef NVME_RXRC_PARCHK_EN
    logic perr_q;
    logic beat_perr;

    // tuser[43 + 4*dw + byte] carries the odd parity of that tdata byte.
    always_comb begin
        beat_perr = 1'b0;
        for (int d = 0; d < 4; d++) begin
            for (int b = 0; b < 4; b++) begin
                if (m_axis_rc_tkeep[d] &&
                    (m_axis_rc_tuser[43 + d*4 + b] != ~^m_axis_rc_tdata[d*32 + b*8 +: 8])) begin
                    beat_perr = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            perr_q <= 1'b0;
        end else if (beat_ok && beat_perr) begin
            perr_q <= 1'b1;
        end
    end

    assign user_rxrc_perror_ind = perr_q;

    logic unused_bits;
    assign unused_bits = ^{m_axis_rc_tdata[95:72], m_axis_rc_tdata[63:47], m_axis_rc_tuser[41:0]};
`else
    assign user_rxrc_perror_ind = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{m_axis_rc_tdata[95:72], m_axis_rc_tdata[63:47], m_axis_rc_tuser[74:43],
                           m_axis_rc_tuser[41:0], m_axis_rc_tkeep, beat_ok};
`endif

endmodule

// File: tb/tb_nvme_pcie_rxrc.sv
// Directed bench for nvme_pcie_rxrc: single/dual dword completions, error status, discards, pending drops, back-pressure, reset and parity.
module tb_nvme_pcie_rxrc;

    logic         user_clk = 1'b0;
    logic         user_reset_n;
    logic [127:0] m_axis_rc_tdata;
    logic [3:0]   m_axis_rc_tkeep;
    logic         m_axis_rc_tlast;
    logic [74:0]  m_axis_rc_tuser;
    logic         m_axis_rc_tvalid;
    logic [21:0]  m_axis_rc_tready;
    logic         rxrc_ctl_valid;
    logic [5:0]   rxrc_ctl_tag;
    logic [63:0]  rxrc_ctl_data;
    logic [7:0]   rxrc_ctl_datap;
    logic [2:0]   rxrc_ctl_status;
    logic         rxrc_ctl_err;
    logic         ctl_rxrc_ack;
    logic [15:0]  rxrc_discard_cnt;
    logic         user_rxrc_perror_ind;

    int checks = 0;
    int errors = 0;

`ifdef NVME_RXRC_PARCHK_EN
    localparam logic PERR_EXP = 1'b1;
`else
    localparam logic PERR_EXP = 1'b0;
`endif

    always #5 user_clk = ~user_clk;

    nvme_pcie_rxrc #(.bits_per_parity_bit(8), .cnt_width(16)) dut (
        .user_clk             (user_clk),
        .user_reset_n         (user_reset_n),
        .m_axis_rc_tdata      (m_axis_rc_tdata),
        .m_axis_rc_tkeep      (m_axis_rc_tkeep),
        .m_axis_rc_tlast      (m_axis_rc_tlast),
        .m_axis_rc_tuser      (m_axis_rc_tuser),
        .m_axis_rc_tvalid     (m_axis_rc_tvalid),
        .m_axis_rc_tready     (m_axis_rc_tready),
        .rxrc_ctl_valid       (rxrc_ctl_valid),
        .rxrc_ctl_tag         (rxrc_ctl_tag),
        .rxrc_ctl_data        (rxrc_ctl_data),
        .rxrc_ctl_datap       (rxrc_ctl_datap),
        .rxrc_ctl_status      (rxrc_ctl_status),
        .rxrc_ctl_err         (rxrc_ctl_err),
        .ctl_rxrc_ack         (ctl_rxrc_ack),
        .rxrc_discard_cnt     (rxrc_discard_cnt),
        .user_rxrc_perror_ind (user_rxrc_perror_ind)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [127:0] desc(input logic [7:0] tag, input logic [10:0] cnt,
                                          input logic [2:0] st, input logic poison,
                                          input logic [31:0] dw0);
        logic [127:0] d;
        d          = '0;
        d[127:96]  = dw0;
        d[71:64]   = tag;
        d[46]      = poison;
        d[45:43]   = st;
        d[42:32]   = cnt;
        d[30]      = 1'b1;
        return d;
    endfunction

    function automatic logic [31:0] byte_par(input logic [127:0] d);
        logic [31:0] p;
        for (int i = 0; i < 16; i++) p[i] = ~^d[i*8 +: 8];
        return p;
    endfunction

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic send_beat(input logic [127:0] d, input logic [3:0] k, input logic last,
                             input logic disc, input logic flip);
        logic rdy;
        int   budget;
        m_axis_rc_tdata  = d;
        m_axis_rc_tkeep  = k;
        m_axis_rc_tlast  = last;
        m_axis_rc_tuser  = {byte_par(d), disc, 42'h0};
        if (flip) m_axis_rc_tuser[43] = ~m_axis_rc_tuser[43];
        m_axis_rc_tvalid = 1'b1;
        budget = 0;
        do begin
            rdy = m_axis_rc_tready[0];
            tick();
            budget++;
        end while (!rdy && budget < 50);
        if (!rdy) check("accept_timeout", 64'(rdy), 64'h1);
        m_axis_rc_tvalid = 1'b0;
        m_axis_rc_tlast  = 1'b0;
        m_axis_rc_tuser  = '0;
    endtask

    task automatic do_ack();
        ctl_rxrc_ack = 1'b1;
        tick();
        ctl_rxrc_ack = 1'b0;
    endtask

    initial begin
        user_reset_n     = 1'b0;
        m_axis_rc_tdata  = '0;
        m_axis_rc_tkeep  = '0;
        m_axis_rc_tlast  = 1'b0;
        m_axis_rc_tuser  = '0;
        m_axis_rc_tvalid = 1'b0;
        ctl_rxrc_ack     = 1'b0;
        tick();
        tick();
        check("rst_tready", 64'(m_axis_rc_tready), 64'h0);
        check("rst_valid", 64'(rxrc_ctl_valid), 64'h0);
        check("rst_data", rxrc_ctl_data, 64'h0);
        check("rst_disc", 64'(rxrc_discard_cnt), 64'h0);
        check("rst_perr", 64'(user_rxrc_perror_ind), 64'h0);
        user_reset_n = 1'b1;
        tick();
        check("idle_tready", 64'(m_axis_rc_tready), 64'h3FFFFF);

        // ack outside S_HOLD must be ignored
        do_ack();
        check("stray_ack_valid", 64'(rxrc_ctl_valid), 64'h0);

        // 1-dword MRd completion
        send_beat(desc(8'h05, 11'd1, 3'd0, 1'b0, 32'hDEADBEEF), 4'hF, 1'b1, 1'b0, 1'b0);
        check("t1_valid", 64'(rxrc_ctl_valid), 64'h1);
        check("t1_tag", 64'(rxrc_ctl_tag), 64'h05);
        check("t1_data", rxrc_ctl_data, 64'h00000000DEADBEEF);
        check("t1_datap", 64'(rxrc_ctl_datap), 64'hFA);
        check("t1_err", 64'(rxrc_ctl_err), 64'h0);
        check("t1_status", 64'(rxrc_ctl_status), 64'h0);
        check("t1_hold_tready", 64'(m_axis_rc_tready), 64'h0);
        do_ack();
        check("t1_ack_valid", 64'(rxrc_ctl_valid), 64'h0);
        check("t1_ack_tready", 64'(m_axis_rc_tready), 64'h3FFFFF);

        // 2-dword completion over two beats
        send_beat(desc(8'h02, 11'd2, 3'd0, 1'b0, 32'h11223344), 4'hF, 1'b0, 1'b0, 1'b0);
        check("t2_mid_valid", 64'(rxrc_ctl_valid), 64'h0);
        check("t2_mid_tready", 64'(m_axis_rc_tready), 64'h3FFFFF);
        send_beat({96'h0, 32'h55667788}, 4'h1, 1'b1, 1'b0, 1'b0);
        check("t2_valid", 64'(rxrc_ctl_valid), 64'h1);
        check("t2_data", rxrc_ctl_data, 64'h5566778811223344);
        check("t2_datap", 64'(rxrc_ctl_datap), 64'hFF);
        check("t2_err", 64'(rxrc_ctl_err), 64'h0);
        tick();
        tick();
        check("t2_hold_tready", 64'(m_axis_rc_tready), 64'h0);
        do_ack();

        // UR completion
        send_beat(desc(8'h3F, 11'd0, 3'd1, 1'b0, 32'h0), 4'h7, 1'b1, 1'b0, 1'b0);
        check("ur_tag", 64'(rxrc_ctl_tag), 64'h3F);
        check("ur_status", 64'(rxrc_ctl_status), 64'h1);
        check("ur_err", 64'(rxrc_ctl_err), 64'h1);
        check("ur_data", rxrc_ctl_data, 64'h0);
        do_ack();

        // bad tag over three beats, then a good completion
        send_beat(desc(8'h45, 11'd1, 3'd0, 1'b0, 32'hAAAA5555), 4'hF, 1'b0, 1'b0, 1'b0);
        send_beat(128'h1, 4'hF, 1'b0, 1'b0, 1'b0);
        send_beat(128'h2, 4'hF, 1'b1, 1'b0, 1'b0);
        check("bad_tag_disc", 64'(rxrc_discard_cnt), 64'h1);
        check("bad_tag_valid", 64'(rxrc_ctl_valid), 64'h0);
        send_beat(desc(8'h01, 11'd1, 3'd0, 1'b0, 32'hCAFEF00D), 4'hF, 1'b1, 1'b0, 1'b0);
        check("good_tag", 64'(rxrc_ctl_tag), 64'h01);
        check("good_data", rxrc_ctl_data, 64'h00000000CAFEF00D);
        do_ack();

        // dword count 3 on a single beat: discarded, straight back to idle
        send_beat(desc(8'h04, 11'd3, 3'd0, 1'b0, 32'h0), 4'hF, 1'b1, 1'b0, 1'b0);
        check("bad_cnt_disc", 64'(rxrc_discard_cnt), 64'h2);
        check("bad_cnt_tready", 64'(m_axis_rc_tready), 64'h3FFFFF);

        // poisoned, discontinue and short payload all flag err
        send_beat(desc(8'h07, 11'd1, 3'd0, 1'b1, 32'h12345678), 4'hF, 1'b1, 1'b0, 1'b0);
        check("poison_err", 64'(rxrc_ctl_err), 64'h1);
        check("poison_status", 64'(rxrc_ctl_status), 64'h0);
        do_ack();
        send_beat(desc(8'h0A, 11'd2, 3'd0, 1'b0, 32'h0BADF00D), 4'hF, 1'b0, 1'b0, 1'b0);
        send_beat({96'h0, 32'h76543210}, 4'h1, 1'b1, 1'b1, 1'b0);
        check("discont_err", 64'(rxrc_ctl_err), 64'h1);
        check("discont_data", rxrc_ctl_data, 64'h765432100BADF00D);
        do_ack();
        send_beat(desc(8'h0B, 11'd2, 3'd0, 1'b0, 32'hFEEDFACE), 4'hF, 1'b1, 1'b0, 1'b0);
        check("short_err", 64'(rxrc_ctl_err), 64'h1);
        check("short_data", rxrc_ctl_data, 64'h00000000FEEDFACE);
        do_ack();

        // second beat without tlast: trailing beat dropped after ack
        send_beat(desc(8'h0C, 11'd2, 3'd0, 1'b0, 32'h01020304), 4'hF, 1'b0, 1'b0, 1'b0);
        send_beat({96'h0, 32'h05060708}, 4'hF, 1'b0, 1'b0, 1'b0);
        check("pdrop_data", rxrc_ctl_data, 64'h0506070801020304);
        do_ack();
        send_beat(desc(8'h2A, 11'd1, 3'd0, 1'b0, 32'h99999999), 4'hF, 1'b1, 1'b0, 1'b0);
        check("pdrop_no_deliver", 64'(rxrc_ctl_valid), 64'h0);
        send_beat(desc(8'h0D, 11'd1, 3'd0, 1'b0, 32'h13579BDF), 4'hF, 1'b1, 1'b0, 1'b0);
        check("pdrop_next_tag", 64'(rxrc_ctl_tag), 64'h0D);
        do_ack();

        // corrupted tuser[43]; data still delivered, perror sticky when checker built in
        send_beat(desc(8'h0E, 11'd1, 3'd0, 1'b0, 32'h2468ACE0), 4'hF, 1'b1, 1'b0, 1'b1);
        check("par_data", rxrc_ctl_data, 64'h000000002468ACE0);
        check("par_perr", 64'(user_rxrc_perror_ind), 64'(PERR_EXP));
        do_ack();
        send_beat(desc(8'h0F, 11'd1, 3'd0, 1'b0, 32'h1), 4'hF, 1'b1, 1'b0, 1'b0);
        do_ack();
        check("par_sticky", 64'(user_rxrc_perror_ind), 64'(PERR_EXP));

        // ack held off with tvalid asserted
        send_beat(desc(8'h09, 11'd1, 3'd0, 1'b0, 32'h00000009), 4'hF, 1'b1, 1'b0, 1'b0);
        m_axis_rc_tdata  = desc(8'h10, 11'd1, 3'd0, 1'b0, 32'h0000AB10);
        m_axis_rc_tkeep  = 4'hF;
        m_axis_rc_tlast  = 1'b1;
        m_axis_rc_tuser  = {byte_par(m_axis_rc_tdata), 43'h0};
        m_axis_rc_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_tready", 64'(m_axis_rc_tready), 64'h0);
        end
        check("bp_tag_stable", 64'(rxrc_ctl_tag), 64'h09);
        do_ack();
        send_beat(desc(8'h10, 11'd1, 3'd0, 1'b0, 32'h0000AB10), 4'hF, 1'b1, 1'b0, 1'b0);
        check("bp_next_tag", 64'(rxrc_ctl_tag), 64'h10);
        check("bp_next_data", rxrc_ctl_data, 64'h000000000000AB10);

        // reset while holding
        user_reset_n = 1'b0;
        #1;
        check("hold_rst_valid", 64'(rxrc_ctl_valid), 64'h0);
        check("hold_rst_tready", 64'(m_axis_rc_tready), 64'h0);
        check("hold_rst_disc", 64'(rxrc_discard_cnt), 64'h0);
        check("hold_rst_perr", 64'(user_rxrc_perror_ind), 64'h0);
        tick();
        user_reset_n = 1'b1;
        tick();
        check("post_rst_tready", 64'(m_axis_rc_tready), 64'h3FFFFF);
        send_beat(desc(8'h11, 11'd1, 3'd0, 1'b0, 32'h77777777), 4'hF, 1'b1, 1'b0, 1'b0);
        check("post_rst_tag", 64'(rxrc_ctl_tag), 64'h11);
        do_ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nvme_pcie_rxrc.md
Name: nvme_pcie_rxrc

Overview:
Receives Xilinx Requester Completion (RC) AXIS completions and returns them to the NVMe control path. These are completions for the CfgRd0 and MRd_64 requests issued on the RQ interface. Each completion is decoded, its tag is checked, up to 2 dwords of payload are captured, byte parity is generated, and the result is presented on a valid/ack handshake toward the control interface. Completions with an unexpected tag or length are discarded and counted.

Parameters:
bits_per_parity_bit, 8, data bits covered by each odd parity bit on rxrc_ctl_datap.
cnt_width, 16, width of the saturating discard counter.

Ports:
user_clk  in  1  clock; all logic is in this domain.
user_reset_n  in  1  asynchronous active-low reset.
m_axis_rc_tdata  in  128  RC data; descriptor plus payload.
m_axis_rc_tkeep  in  4  dword valid mask.
m_axis_rc_tlast  in  1  last beat of the completion.
m_axis_rc_tuser  in  75  RC sideband; [74:43] = tdata parity, [42] = discontinue.
m_axis_rc_tvalid  in  1  beat valid.
m_axis_rc_tready  out  22  ready; all bits driven identically.
rxrc_ctl_valid  out  1  completion available.
rxrc_ctl_tag  out  6  tag of the completed request.
rxrc_ctl_data  out  64  payload; DW0 in [31:0], DW1 in [63:32].
rxrc_ctl_datap  out  8  odd parity of rxrc_ctl_data, one bit per byte.
rxrc_ctl_status  out  3  completion status (0 = SC, 1 = UR, 2 = CRS, 4 = CA).
rxrc_ctl_err  out  1  status nonzero, poisoned, discontinue, or short payload.
ctl_rxrc_ack  in  1  control path consumed the completion.
rxrc_discard_cnt  out  cnt_width  saturating count of discarded completions.
user_rxrc_perror_ind  out  1  sticky parity error indication.

Behaviour:
- Reset: all outputs 0; m_axis_rc_tready = 0 while user_reset_n is low, then all ones in S_IDLE. State returns to S_IDLE. Reset mid-packet abandons the packet. The remaining beats of that packet are accepted in S_IDLE and treated as new packets; the RC core guarantees this cannot happen in normal operation.
- First-beat descriptor fields:
  - [42:32] dword count.
  - [45:43] status.
  - [46] poisoned.
  - [71:64] tag.
  - [30] request completed.
  - DW0 payload at tdata[127:96].
- States:
  - S_IDLE: tready = 1. On tvalid, decode the first beat.
    - tag[7:6] != 0, or dword count > 2 → S_DROP. If tlast is set on this beat, go instead straight to S_IDLE. Either way, discard_cnt +1 (saturates at all ones).
    - status != 0 → capture tag and status; data = 0, err = 1 → S_HOLD. Any remaining beats are dropped via S_DROP after the ack.
    - dword count == 2 and !tlast → capture DW0 → S_DATA2.
    - Otherwise (count <= 1, tlast) → capture DW0; DW1 = 0 → S_HOLD.
    - Dword count == 2 with tlast on the first beat → DW1 = 0, err = 1 → S_HOLD.
  - S_DATA2: tready = 1. On tvalid, DW1 = tdata[31:0] → S_HOLD. If the beat lacks tlast, set a pending-drop flag; after the ack, go to S_DROP instead of S_IDLE.
  - S_DROP: tready = 1. Consume beats until tvalid & tlast → S_IDLE.
  - S_HOLD: tready = 0; rxrc_ctl_valid = 1, with all rxrc_ctl_* stable. On ctl_rxrc_ack → S_IDLE (or S_DROP if the pending-drop flag is set); valid = 0 next cycle.
- Latency: rxrc_ctl_valid rises the cycle after the last payload beat is accepted. Each completion costs at least 1 bubble cycle on tready.
- ctl_rxrc_ack outside S_HOLD is ignored.
- err is also set when tuser[42] (discontinue) or poisoned is seen on any accepted beat of a delivered completion.
- rxrc_ctl_datap is computed from the captured data using odd parity, bits_per_parity_bit bits per parity bit. It is registered with the data.

Optional Feature:
NVME_RXRC_PARCHK_EN:
- Defined: each accepted beat's tdata is checked against tuser[74:43] (odd parity per byte, only for dwords enabled in tkeep). A mismatch sets user_rxrc_perror_ind, which stays set until reset. The completion itself is still delivered.
- Undefined: user_rxrc_perror_ind is tied to 0 and the checker is not instantiated.

Test Plan:
- 1-dword MRd completion: tag 0x05, count 1, status 0, DW0 0xDEADBEEF, tlast on beat 1 → valid next cycle, tag 0x05, data 0x00000000DEADBEEF, err 0, datap odd per byte; after ack, tready = all ones.
- 2-dword completion over 2 beats: DW0 0x11223344, DW1 0x55667788 → data 0x5566778811223344, err 0; tready low until ack.
- UR completion: status 1, count 0, tag 0x3F → status 1, err 1, data 0.
- Bad tag 0x45 (3 beats), then a good completion with tag 0x01 → bad one dropped, discard_cnt 1, only tag 0x01 delivered.
- Ack held off 10 cycles with RC tvalid asserted → tready 0 throughout, no beat lost; assert user_reset_n low in S_HOLD → valid 0 and state S_IDLE immediately.
- NVME_RXRC_PARCHK_EN defined with a flipped tuser[43] → perror_ind 1 and sticky; data still delivered. Same stimulus with the macro undefined → perror_ind stays 0.
